// File: rtl/serial_operand_loader_pkg.sv
// serial_operand_loader_pkg
// Shared definitions for the serial operand loader and the equality
// comparator bench that consumes its operands.
//   phase_e         : loader state, also driven out on the phase port
//   DEFAULT_WIDTH   : operand width used by the 5-bit comparator
//   cnt_width()     : bit-counter width for a given operand width
package serial_operand_loader_pkg;

    typedef enum logic [1:0] {
        PH_LOAD_X = 2'd0,
        PH_LOAD_Y = 2'd1,
        PH_HOLD   = 2'd2
    } phase_e;

    localparam int DEFAULT_WIDTH = 5;

    // Width of a counter that indexes bits 0..w-1; never narrower than 1.
    function automatic int cnt_width(input int w);
        int cw;
        cw = $clog2(w);
        return (cw < 1) ? 1 : cw;
    endfunction

endpackage

// File: rtl/serial_operand_loader_bit_capture_reg.sv
// bit_capture_reg
// WIDTH-bit operand register that is filled one bit at a time.
//   clk, rst_n : clock, asynchronous active-low reset (clears q)
//   clear      : synchronous zeroing, wins over a write in the same cycle
//   wr_en      : write wr_bit into q[wr_idx] on this edge
//   wr_idx     : target bit position (0..WIDTH-1)
//   wr_bit     : value to write
//   q          : register contents; untouched bits keep their value
module bit_capture_reg
    import serial_operand_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_bit,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement or process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (wr_en) begin
            // Decode the index explicitly so only the addressed bit changes.
            for (int i = 0; i < WIDTH; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    q[i] <= wr_bit;
                end
            end
        end
    end

endmodule

// File: rtl/serial_operand_loader.sv
// serial_operand_loader
// Assembles two WIDTH-bit operands (X then Y, LSB first) from a serial
// valid/ready bit stream and presents them in parallel until acknowledged.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous abort back to X loading with zeroed operands
//   in_valid   : in_bit is valid this cycle
//   in_bit     : serial data bit
//   in_ready   : a bit can be accepted this cycle (state-only)
//   x, y       : assembled operands
//   out_valid  : x and y are complete and stable
//   out_ack    : consumer has taken x and y (only honoured in HOLD)
//   phase      : 0 = LOAD_X, 1 = LOAD_Y, 2 = HOLD
module serial_operand_loader
    import serial_operand_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ack,
    output logic [1:0]       phase
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    phase_e        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          take;
    logic          last;

    assign in_ready = (state == PH_LOAD_X) || (state == PH_LOAD_Y);
    assign take     = in_valid && in_ready;
    assign last     = (cnt == LAST);
    assign phase    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PH_LOAD_X;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            // Registered flag: high exactly while the state register is HOLD.
            out_valid <= (state_d == PH_HOLD);
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (clear) begin
            state_d = PH_LOAD_X;
            cnt_d   = '0;
        end else begin
            case (state)
                PH_LOAD_X: begin
                    if (take) begin
                        if (last) begin
                            state_d = PH_LOAD_Y;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt + 1'b1;
                        end
                    end
                end
                PH_LOAD_Y: begin
                    if (take) begin
                        if (last) begin
                            state_d = PH_HOLD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt + 1'b1;
                        end
                    end
                end
                PH_HOLD: begin
                    if (out_ack) begin
                        state_d = PH_LOAD_X;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    // Unused encoding 3 falls back to the start of loading.
                    state_d = PH_LOAD_X;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    bit_capture_reg #(.WIDTH(WIDTH), .IDX_W(CW)) u_x_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .wr_en  (take && (state == PH_LOAD_X)),
        .wr_idx (cnt),
        .wr_bit (in_bit),
        .q      (x)
    );

    bit_capture_reg #(.WIDTH(WIDTH), .IDX_W(CW)) u_y_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .wr_en  (take && (state == PH_LOAD_Y)),
        .wr_idx (cnt),
        .wr_bit (in_bit),
        .q      (y)
    );

endmodule
